// File: rtl/wb_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : wb_arbiter2
//  Purpose  : Two-master Wishbone arbiter. It shares one slave port between
//             the instruction-fetch master (I) and the load/store master (D).
//             Arbitration is round-robin and happens once per bus cycle. The
//             grant is held for as long as the owning master keeps cyc high.
//             A watchdog ends any granted cycle that the slave leaves
//             unanswered.
//  Params   : TIMEOUT - strobe cycles allowed without ack/err (>= 2)
//             CW      - watchdog counter width (must hold TIMEOUT)
//  Ports    : clk, rst (async, active-low)
//             i_* / d_* master inputs  : addr, dat, sel, cyc, stb, we
//             i_* / d_* master outputs : dat_o, ack_o, err_o
//             s_* slave outputs        : addr, dat, sel, cyc, stb, we
//             s_* slave inputs         : dat_i, ack_i, err_i
//             timeout_o                : one-cycle pulse when the watchdog fires
//  Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter2 #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  // instruction-fetch master
  input  logic [31:0] i_addr_i,
  input  logic [31:0] i_dat_i,
  input  logic [3:0]  i_sel_i,
  input  logic        i_cyc_i,
  input  logic        i_stb_i,
  input  logic        i_we_i,
  output logic [31:0] i_dat_o,
  output logic        i_ack_o,
  output logic        i_err_o,
  // load/store master
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_sel_i,
  input  logic        d_cyc_i,
  input  logic        d_stb_i,
  input  logic        d_we_i,
  output logic [31:0] d_dat_o,
  output logic        d_ack_o,
  output logic        d_err_o,
  // shared slave
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  // watchdog
  output logic        timeout_o
);

  localparam logic [1:0]    c_st_idle  = 2'd0;
  localparam logic [1:0]    c_st_gnt_i = 2'd1;
  localparam logic [1:0]    c_st_gnt_d = 2'd2;
  localparam logic          c_m_i      = 1'b0;
  localparam logic          c_m_d      = 1'b1;
  localparam logic [CW-1:0] c_timeout  = CW'(TIMEOUT);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_last;        // master served most recently
  logic          w_last_nxt;
  logic [CW-1:0] r_cnt;         // strobe cycles spent waiting on the slave

  logic w_req_i;
  logic w_req_d;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_own_stb;
  logic w_timeout;

  assign w_req_i = i_cyc_i & i_stb_i;
  assign w_req_d = d_cyc_i & d_stb_i;
  assign w_gnt_i = (r_state == c_st_gnt_i);
  assign w_gnt_d = (r_state == c_st_gnt_d);

  // Strobe of whichever master currently owns the slave (0 when idle).
  assign w_own_stb = (w_gnt_i & i_stb_i) | (w_gnt_d & d_stb_i);

  // The watchdog fires on the cycle the wait count reaches TIMEOUT, so the
  // slave gets exactly TIMEOUT waiting cycles before the forced error.
  assign w_timeout = (w_gnt_i | w_gnt_d) && (r_cnt == c_timeout);

  // --------------------------------------------------------------------------
  // Next-state / round-robin decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      c_st_idle: begin
        // I wins when it requests alone or when a tie favours it
        // (D was served last).
        if (w_req_i && (!w_req_d || (r_last == c_m_d))) begin
          w_state_nxt = c_st_gnt_i;
          w_last_nxt  = c_m_i;
        end else if (w_req_d) begin
          w_state_nxt = c_st_gnt_d;
          w_last_nxt  = c_m_d;
        end
      end
      c_st_gnt_i: begin
        if (w_timeout || !i_cyc_i) w_state_nxt = c_st_idle;
      end
      c_st_gnt_d: begin
        if (w_timeout || !d_cyc_i) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_st_idle;
      r_last  <= c_m_d;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog counter
  // --------------------------------------------------------------------------
  // The counter also clears on the timeout cycle itself. The following IDLE
  // cycle would clear it anyway, and clearing early keeps the count from
  // ever running past TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if ((r_state == c_st_idle) || s_ack_i || s_err_i || w_timeout) begin
      r_cnt <= '0;
    end else if (w_own_stb) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Bus routing: slave side mirrors the granted master; responses go back
  // only to that master. During a timeout the slave strobe is withdrawn and
  // the slave's own ack/err are masked in favour of the forced error.
  // --------------------------------------------------------------------------
  always_comb begin
    s_addr_o  = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    i_dat_o   = '0;
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    d_dat_o   = '0;
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    timeout_o = w_timeout;
    case (r_state)
      c_st_gnt_i: begin
        s_addr_o = i_addr_i;
        s_dat_o  = i_dat_i;
        s_sel_o  = i_sel_i;
        s_we_o   = i_we_i;
        s_cyc_o  = i_cyc_i & ~w_timeout;
        s_stb_o  = i_stb_i & ~w_timeout;
        i_dat_o  = s_dat_i;
        i_ack_o  = s_ack_i & ~w_timeout;
        i_err_o  = s_err_i | w_timeout;
      end
      c_st_gnt_d: begin
        s_addr_o = d_addr_i;
        s_dat_o  = d_dat_i;
        s_sel_o  = d_sel_i;
        s_we_o   = d_we_i;
        s_cyc_o  = d_cyc_i & ~w_timeout;
        s_stb_o  = d_stb_i & ~w_timeout;
        d_dat_o  = s_dat_i;
        d_ack_o  = s_ack_i & ~w_timeout;
        d_err_o  = s_err_i | w_timeout;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_wb_arbiter2
//  Purpose  : Self-checking bench for wb_arbiter2 (TIMEOUT = 4). A queue
//             holds the expected master responses (which master is acked,
//             and with what data). The bench pushes an entry when it drives
//             a slave ack and pops it when the arbiter presents the ack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter2;

  localparam int TIMEOUT = 4;
  localparam int CW      = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_addr_i, i_dat_i, d_addr_i, d_dat_i;
  logic [3:0]  i_sel_i, d_sel_i;
  logic        i_cyc_i, i_stb_i, i_we_i, d_cyc_i, d_stb_i, d_we_i;
  logic [31:0] i_dat_o, d_dat_o, s_addr_o, s_dat_o, s_dat_i;
  logic        i_ack_o, i_err_o, d_ack_o, d_err_o;
  logic [3:0]  s_sel_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, timeout_o;

  logic [139:0] all_out;
  assign all_out = {s_addr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o,
                    i_dat_o, i_ack_o, i_err_o, d_dat_o, d_ack_o, d_err_o, timeout_o};

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .i_addr_i(i_addr_i), .i_dat_i(i_dat_i), .i_sel_i(i_sel_i),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_we_i(i_we_i),
    .i_dat_o(i_dat_o), .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_addr_i(d_addr_i), .d_dat_i(d_dat_i), .d_sel_i(d_sel_i),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i),
    .d_dat_o(d_dat_o), .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .timeout_o(timeout_o)
  );

  typedef struct packed { logic is_d; logic [31:0] dat; } exp_t;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic model_last_d;   // round-robin model: 1 = D served last

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_addr_i = 32'hDEAD_0000; i_dat_i = 32'h1111_1111; i_sel_i = 4'hF;
    d_addr_i = 32'hBEEF_0000; d_dat_i = 32'h2222_2222; d_sel_i = 4'hF;
    i_cyc_i = 0; i_stb_i = 0; i_we_i = 1;
    d_cyc_i = 0; d_stb_i = 0; d_we_i = 1;
    s_dat_i = 32'h3333_3333; s_ack_i = 1; s_err_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin
      n_errors++; $display("FAIL reset_slave_ctl: cyc/stb/we=%b expected 000", {s_cyc_o, s_stb_o, s_we_o});
    end
    n_checks++;
    if ({s_addr_o, s_dat_o, s_sel_o} !== '0) begin
      n_errors++; $display("FAIL reset_slave_data: addr=%h dat=%h sel=%h expected 0", s_addr_o, s_dat_o, s_sel_o);
    end
    n_checks++;
    if ({i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o, i_dat_o, d_dat_o} !== '0) begin
      n_errors++; $display("FAIL reset_master_resp: i_ack=%b i_err=%b d_ack=%b d_err=%b to=%b expected all 0",
                           i_ack_o, i_err_o, d_ack_o, d_err_o, timeout_o);
    end
    i_we_i = 0; d_we_i = 0; s_ack_i = 0; s_err_i = 0; s_dat_i = 0;
    rst = 1'b1;
    model_last_d = 1'b1;
  endtask

  // Both masters request from reset; each granted master does one beat,
  // drops cyc for a cycle and requests again. The grants should run I,D,I,D.
  task automatic test_round_robin();
    exp_t ex;
    logic exp_d;
    next_cycle();
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'h100;
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = 32'h200;
    @(negedge clk);
    n_checks++;
    if (s_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL rr_latency: s_cyc_o=%b expected 0 in request cycle", s_cyc_o);
    end
    for (int k = 0; k < 4; k++) begin
      exp_d = ~model_last_d;
      model_last_d = exp_d;
      next_cycle();
      s_ack_i = 1; s_dat_i = 32'hA000_0000 | 32'(k);
      sb_q.push_back('{is_d: exp_d, dat: 32'hA000_0000 | 32'(k)});
      @(negedge clk);
      n_checks++;
      if (s_addr_o !== (exp_d ? 32'h200 : 32'h100) || s_cyc_o !== 1'b1) begin
        n_errors++; $display("FAIL rr_grant%0d: s_addr_o=%h s_cyc_o=%b expected addr=%h cyc=1",
                             k, s_addr_o, s_cyc_o, exp_d ? 32'h200 : 32'h100);
      end
      ex = sb_q.pop_front();
      n_checks++;
      if ((ex.is_d ? d_ack_o : i_ack_o) !== 1'b1 || (ex.is_d ? d_dat_o : i_dat_o) !== ex.dat) begin
        n_errors++; $display("FAIL rr_resp%0d: ack=%b dat=%h expected ack=1 dat=%h", k,
                             ex.is_d ? d_ack_o : i_ack_o, ex.is_d ? d_dat_o : i_dat_o, ex.dat);
      end
      n_checks++;
      if ((exp_d ? i_ack_o : d_ack_o) !== 1'b0) begin
        n_errors++; $display("FAIL rr_other_ack%0d: got 1 expected 0", k);
      end
      next_cycle();
      s_ack_i = 0; s_dat_i = 0;
      if (exp_d || k == 3) begin d_cyc_i = 0; d_stb_i = 0; end
      if (!exp_d || k == 3) begin i_cyc_i = 0; i_stb_i = 0; end
      @(negedge clk);
      n_checks++;
      if (s_cyc_o !== 1'b0) begin
        n_errors++; $display("FAIL rr_drop%0d: s_cyc_o=%b expected 0 same cycle", k, s_cyc_o);
      end
      next_cycle();
      if (k < 3) begin
        if (exp_d) begin d_cyc_i = 1; d_stb_i = 1; end
        else begin i_cyc_i = 1; i_stb_i = 1; end
      end
      @(negedge clk);
      n_checks++;
      if (s_cyc_o !== 1'b0) begin
        n_errors++; $display("FAIL rr_idle_gap%0d: s_cyc_o=%b expected 0", k, s_cyc_o);
      end
    end
  endtask

  task automatic test_single_i_read();
    exp_t ex;
    next_cycle();
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'h10; i_we_i = 0; i_sel_i = 4'hF;
    next_cycle();
    model_last_d = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_addr_o !== 32'h10 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || i_ack_o !== 1'b0) begin
      n_errors++; $display("FAIL read_addr: addr=%h cyc=%b stb=%b i_ack=%b expected 10/1/1/0",
                           s_addr_o, s_cyc_o, s_stb_o, i_ack_o);
    end
    next_cycle();
    s_ack_i = 1; s_dat_i = 32'h0000_0193;
    sb_q.push_back('{is_d: 1'b0, dat: 32'h0000_0193});
    @(negedge clk);
    ex = sb_q.pop_front();
    n_checks++;
    if ((ex.is_d ? d_ack_o : i_ack_o) !== 1'b1 || (ex.is_d ? d_dat_o : i_dat_o) !== ex.dat) begin
      n_errors++; $display("FAIL read_resp: i_ack=%b i_dat=%h expected 1/%h", i_ack_o, i_dat_o, ex.dat);
    end
    n_checks++;
    if (d_ack_o !== 1'b0 || d_dat_o !== 32'h0) begin
      n_errors++; $display("FAIL read_d_quiet: d_ack=%b d_dat=%h expected 0/0", d_ack_o, d_dat_o);
    end
    next_cycle();
    s_ack_i = 0; s_dat_i = 0; i_cyc_i = 0; i_stb_i = 0;
    next_cycle();
  endtask

  // D holds cyc for three write beats while I waits.
  task automatic test_d_burst();
    exp_t ex;
    next_cycle();
    d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_sel_i = 4'b0011; d_addr_i = 32'h300;
    next_cycle();
    model_last_d = 1'b1;
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'h400; i_we_i = 0;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) next_cycle();
      d_addr_i = 32'h300 + 32'(4 * b); d_dat_i = 32'h5500_0000 + 32'(b);
      s_ack_i = 1; s_dat_i = 32'h1000 + 32'(b);
      sb_q.push_back('{is_d: 1'b1, dat: 32'h1000 + 32'(b)});
      @(negedge clk);
      n_checks++;
      if ({s_we_o, s_sel_o} !== 5'b1_0011 || s_addr_o !== 32'h300 + 32'(4 * b)
          || s_dat_o !== 32'h5500_0000 + 32'(b)) begin
        n_errors++; $display("FAIL burst_beat%0d: we=%b sel=%b addr=%h dat=%h expected 1/0011/%h/%h", b,
                             s_we_o, s_sel_o, s_addr_o, s_dat_o, 32'h300 + 32'(4 * b), 32'h5500_0000 + 32'(b));
      end
      ex = sb_q.pop_front();
      n_checks++;
      if ((ex.is_d ? d_ack_o : i_ack_o) !== 1'b1 || (ex.is_d ? d_dat_o : i_dat_o) !== ex.dat
          || i_ack_o !== 1'b0) begin
        n_errors++; $display("FAIL burst_resp%0d: d_ack=%b d_dat=%h i_ack=%b expected 1/%h/0", b,
                             d_ack_o, d_dat_o, i_ack_o, ex.dat);
      end
    end
    next_cycle();
    s_ack_i = 0; s_dat_i = 0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (s_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL burst_idle: s_cyc_o=%b expected 0", s_cyc_o);
    end
    next_cycle();
    model_last_d = 1'b0;
    s_ack_i = 1; s_dat_i = 32'h77;
    sb_q.push_back('{is_d: 1'b0, dat: 32'h77});
    @(negedge clk);
    n_checks++;
    if (s_addr_o !== 32'h400 || s_cyc_o !== 1'b1 || s_we_o !== 1'b0) begin
      n_errors++; $display("FAIL burst_then_i: addr=%h cyc=%b we=%b expected 400/1/0", s_addr_o, s_cyc_o, s_we_o);
    end
    ex = sb_q.pop_front();
    n_checks++;
    if ((ex.is_d ? d_ack_o : i_ack_o) !== 1'b1 || (ex.is_d ? d_dat_o : i_dat_o) !== ex.dat) begin
      n_errors++; $display("FAIL burst_i_resp: i_ack=%b i_dat=%h expected 1/%h", i_ack_o, i_dat_o, ex.dat);
    end
    next_cycle();
    s_ack_i = 0; s_dat_i = 0; i_cyc_i = 0; i_stb_i = 0;
    next_cycle();
  endtask

  // I is granted, the slave stays silent and D waits. The error must land on
  // grant cycle TIMEOUT+1, when the registered wait count equals TIMEOUT.
  task automatic test_timeout();
    exp_t ex;
    next_cycle();
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'h500;
    next_cycle();
    model_last_d = 1'b0;
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = 32'h600;
    for (int w = 1; w <= TIMEOUT; w++) begin
      if (w > 1) next_cycle();
      @(negedge clk);
      n_checks++;
      if (i_err_o !== 1'b0 || timeout_o !== 1'b0 || s_stb_o !== 1'b1) begin
        n_errors++; $display("FAIL wd_wait%0d: i_err=%b to=%b stb=%b expected 0/0/1", w, i_err_o, timeout_o, s_stb_o);
      end
    end
    next_cycle();
    s_ack_i = 1;
    @(negedge clk);
    n_checks++;
    if (i_err_o !== 1'b1 || timeout_o !== 1'b1 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0) begin
      n_errors++; $display("FAIL wd_fire: i_err=%b to=%b stb=%b cyc=%b expected 1/1/0/0",
                           i_err_o, timeout_o, s_stb_o, s_cyc_o);
    end
    n_checks++;
    if (i_ack_o !== 1'b0 || d_ack_o !== 1'b0 || d_err_o !== 1'b0) begin
      n_errors++; $display("FAIL wd_ack_masked: i_ack=%b d_ack=%b d_err=%b expected 0/0/0", i_ack_o, d_ack_o, d_err_o);
    end
    next_cycle();
    s_ack_i = 0;
    @(negedge clk);
    n_checks++;
    if (s_cyc_o !== 1'b0 || timeout_o !== 1'b0) begin
      n_errors++; $display("FAIL wd_to_idle: s_cyc_o=%b to=%b expected 0/0 with i_cyc still high", s_cyc_o, timeout_o);
    end
    next_cycle();
    model_last_d = 1'b1;
    i_cyc_i = 0; i_stb_i = 0;
    s_ack_i = 1; s_dat_i = 32'h66;
    sb_q.push_back('{is_d: 1'b1, dat: 32'h66});
    @(negedge clk);
    n_checks++;
    if (s_addr_o !== 32'h600 || s_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL wd_next_d: addr=%h cyc=%b expected 600/1", s_addr_o, s_cyc_o);
    end
    ex = sb_q.pop_front();
    n_checks++;
    if ((ex.is_d ? d_ack_o : i_ack_o) !== 1'b1 || (ex.is_d ? d_dat_o : i_dat_o) !== ex.dat) begin
      n_errors++; $display("FAIL wd_d_resp: d_ack=%b d_dat=%h expected 1/%h", d_ack_o, d_dat_o, ex.dat);
    end
    next_cycle();
    s_ack_i = 0; s_dat_i = 0; d_cyc_i = 0; d_stb_i = 0;
    next_cycle();
  endtask

  task automatic test_abort();
    next_cycle();
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'h700;
    next_cycle();
    model_last_d = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL abort_grant: s_cyc_o=%b expected 1", s_cyc_o);
    end
    next_cycle();
    i_cyc_i = 0; i_stb_i = 0;
    @(negedge clk);
    n_checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      n_errors++; $display("FAIL abort_same_cycle: cyc=%b stb=%b expected 0/0", s_cyc_o, s_stb_o);
    end
    next_cycle();
    s_ack_i = 1; s_dat_i = 32'hBAD;
    @(negedge clk);
    n_checks++;
    if (i_ack_o !== 1'b0 || d_ack_o !== 1'b0 || i_dat_o !== 32'h0) begin
      n_errors++; $display("FAIL abort_late_ack: i_ack=%b d_ack=%b i_dat=%h expected 0/0/0", i_ack_o, d_ack_o, i_dat_o);
    end
    next_cycle();
    s_ack_i = 0; s_dat_i = 0;
  endtask

  task automatic test_async_reset();
    next_cycle();
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = 32'h800;
    next_cycle();
    model_last_d = 1'b1;
    s_ack_i = 1; s_dat_i = 32'hCAFE;
    @(negedge clk);
    n_checks++;
    if (d_ack_o !== 1'b1 || s_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL ar_pre: d_ack=%b s_cyc=%b expected 1/1", d_ack_o, s_cyc_o);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_errors++; $display("FAIL ar_async_zero: outputs=%h expected 0", all_out);
    end
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'h900;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) begin
      n_errors++; $display("FAIL ar_held_zero: outputs=%h expected 0", all_out);
    end
    s_ack_i = 0; s_dat_i = 0;
    rst = 1'b1;
    model_last_d = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (s_addr_o !== 32'h900 || s_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL ar_tie_to_i: addr=%h cyc=%b expected 900/1", s_addr_o, s_cyc_o);
    end
    next_cycle();
    i_cyc_i = 0; i_stb_i = 0; d_cyc_i = 0; d_stb_i = 0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_i_read();
    test_d_burst();
    test_timeout();
    test_abort();
    test_async_reset();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++; $display("FAIL sb_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 ns");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
